// File: rtl/pulse_detector_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pulse_detector_pkg : shared types and constants for the detector |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package pulse_detector_pkg;

   localparam int POWER_W     = 32;
   localparam int THR_W       = 48;
   localparam int DEF_MIN_ON  = 3;
   localparam int DEF_MIN_OFF = 3;

   typedef enum logic [2:0] {
      WAIT_THR = 3'd0,
      IDLE     = 3'd1,
      RISE     = 3'd2,
      HIGH     = 3'd3,
      FALL     = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pulse_detector_iq_power.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | iq_power : two-stage re^2 + im^2 with valid/timestamp sidebands  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module iq_power
   import pulse_detector_pkg::*;
#(
   parameter int TS_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [15:0] re_i,
   input  logic signed [15:0] im_i,
   input  logic               valid_i,
   input  logic [TS_W-1:0]    ts_i,
   output logic [POWER_W-1:0] power_o,
   output logic               valid_o,
   output logic [TS_W-1:0]    ts_o
);

   logic signed [31:0] re_sq_w;
   logic signed [31:0] im_sq_w;
   logic [31:0]        re_sq_q;
   logic [31:0]        im_sq_q;
   logic               valid1_q;
   logic [TS_W-1:0]    ts1_q;
   logic [POWER_W-1:0] power_q;
   logic               valid2_q;
   logic [TS_W-1:0]    ts2_q;

   // Each square is at most 2^30, so the sum never exceeds 2^31.
   assign re_sq_w = 32'(re_i) * 32'(re_i);
   assign im_sq_w = 32'(im_i) * 32'(im_i);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         re_sq_q  <= '0;
         im_sq_q  <= '0;
         valid1_q <= 1'b0;
         ts1_q    <= '0;
         power_q  <= '0;
         valid2_q <= 1'b0;
         ts2_q    <= '0;
      end else begin
         re_sq_q  <= $unsigned(re_sq_w);
         im_sq_q  <= $unsigned(im_sq_w);
         valid1_q <= valid_i;
         ts1_q    <= ts_i;
         power_q  <= re_sq_q + im_sq_q;
         valid2_q <= valid1_q;
         ts2_q    <= ts1_q;
      end
   end

   assign power_o = power_q;
   assign valid_o = valid2_q;
   assign ts_o    = ts2_q;

endmodule
`default_nettype wire

// File: rtl/pulse_detector.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pulse_detector : hysteretic pulse start/end with TOA and width   |
// | Optional peak power output when PEAK_POWER_EN is defined. Rev 1.0|
// +-----------------------------------------------------------------+
module pulse_detector
   import pulse_detector_pkg::*;
#(
   parameter int MIN_ON  = DEF_MIN_ON,
   parameter int MIN_OFF = DEF_MIN_OFF,
   parameter int WIDTH_W = 24,
   parameter int TS_W    = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [15:0] real_part,
   input  logic signed [15:0] imag_part,
   input  logic               data_valid,
   input  logic [THR_W-1:0]   threshold,
   input  logic               threshold_calculated,
   output logic               pulse_start,
   output logic               pulse_end,
   output logic [TS_W-1:0]    pulse_toa,
   output logic [WIDTH_W-1:0] pulse_width,
   output logic               in_pulse
`ifdef PEAK_POWER_EN
   ,
   output logic [POWER_W-1:0] pulse_peak
`endif
);

   localparam int CNT_MAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [TS_W-1:0]    ts_q;
   logic [THR_W-1:0]   thr_q;
   logic [POWER_W-1:0] pwr;
   logic               pwr_valid;
   logic [TS_W-1:0]    pwr_ts;

   state_t             state_q;
   logic [CNT_W-1:0]   on_cnt_q;
   logic [CNT_W-1:0]   off_cnt_q;
   logic [WIDTH_W-1:0] width_q;
   logic [TS_W-1:0]    cand_toa_q;
   logic               pulse_start_q;
   logic               pulse_end_q;
   logic               in_pulse_q;
   logic [TS_W-1:0]    pulse_toa_q;
   logic [WIDTH_W-1:0] pulse_width_q;

   logic               above_valid;
   logic               below_valid;
   logic               start_fire;
   logic               end_fire;
   logic [WIDTH_W:0]   width_inc_sum;
   logic [WIDTH_W:0]   width_bridge_sum;
   logic [WIDTH_W-1:0] width_inc_d;
   logic [WIDTH_W-1:0] width_bridge_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_q  <= '0;
         thr_q <= '0;
      end else begin
         if (data_valid) ts_q <= ts_q + 1'b1;
         if (threshold_calculated) thr_q <= threshold;
      end
   end

   iq_power #(
      .TS_W (TS_W)
   ) u_iq_power (
      .clk     (clk),
      .reset   (reset),
      .re_i    (real_part),
      .im_i    (imag_part),
      .valid_i (data_valid),
      .ts_i    (ts_q),
      .power_o (pwr),
      .valid_o (pwr_valid),
      .ts_o    (pwr_ts)
   );

   // A negative or >= 2^32 threshold has nonzero upper bits: nothing is above it.
   assign above_valid = pwr_valid && (thr_q[THR_W-1:POWER_W] == '0) && (pwr > thr_q[POWER_W-1:0]);
   assign below_valid = pwr_valid && !above_valid;

   assign start_fire = threshold_calculated && above_valid &&
                       (((state_q == IDLE) && (MIN_ON == 1)) ||
                        ((state_q == RISE) && (on_cnt_q == CNT_W'(MIN_ON - 1))));
   assign end_fire   = threshold_calculated && below_valid &&
                       (((state_q == HIGH) && (MIN_OFF == 1)) ||
                        ((state_q == FALL) && (off_cnt_q == CNT_W'(MIN_OFF - 1))));

   always_comb begin
      width_inc_sum    = {1'b0, width_q} + (WIDTH_W + 1)'(1);
      width_bridge_sum = {1'b0, width_q} + (WIDTH_W + 1)'(off_cnt_q) + (WIDTH_W + 1)'(1);
      width_inc_d      = width_inc_sum[WIDTH_W]    ? '1 : width_inc_sum[WIDTH_W-1:0];
      width_bridge_d   = width_bridge_sum[WIDTH_W] ? '1 : width_bridge_sum[WIDTH_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= WAIT_THR;
         on_cnt_q      <= '0;
         off_cnt_q     <= '0;
         width_q       <= '0;
         cand_toa_q    <= '0;
         pulse_start_q <= 1'b0;
         pulse_end_q   <= 1'b0;
         in_pulse_q    <= 1'b0;
         pulse_toa_q   <= '0;
         pulse_width_q <= '0;
      end else begin
         pulse_start_q <= 1'b0;
         pulse_end_q   <= 1'b0;
         if (pulse_end_q) in_pulse_q <= 1'b0;

         if (!threshold_calculated) begin
            state_q    <= WAIT_THR;
            on_cnt_q   <= '0;
            off_cnt_q  <= '0;
            width_q    <= '0;
            in_pulse_q <= 1'b0;
         end else begin
            if (start_fire) begin
               pulse_start_q <= 1'b1;
               in_pulse_q    <= 1'b1;
               pulse_toa_q   <= (state_q == IDLE) ? pwr_ts : cand_toa_q;
               width_q       <= WIDTH_W'(MIN_ON);
            end
            if (end_fire) begin
               pulse_end_q   <= 1'b1;
               pulse_width_q <= width_q;
            end

            case (state_q)
               WAIT_THR: state_q <= IDLE;
               IDLE: begin
                  if (above_valid) begin
                     cand_toa_q <= pwr_ts;
                     on_cnt_q   <= CNT_W'(1);
                     state_q    <= (MIN_ON == 1) ? HIGH : RISE;
                  end
               end
               RISE: begin
                  if (above_valid) begin
                     on_cnt_q <= on_cnt_q + 1'b1;
                     if (start_fire) state_q <= HIGH;
                  end else if (below_valid) begin
                     on_cnt_q <= '0;
                     state_q  <= IDLE;
                  end
               end
               HIGH: begin
                  if (above_valid) begin
                     width_q <= width_inc_d;
                  end else if (below_valid) begin
                     off_cnt_q <= CNT_W'(1);
                     state_q   <= end_fire ? IDLE : FALL;
                  end
               end
               FALL: begin
                  // Gap samples are folded back into the width when the pulse resumes.
                  if (above_valid) begin
                     width_q   <= width_bridge_d;
                     off_cnt_q <= '0;
                     state_q   <= HIGH;
                  end else if (below_valid) begin
                     if (end_fire) begin
                        off_cnt_q <= '0;
                        state_q   <= IDLE;
                     end else begin
                        off_cnt_q <= off_cnt_q + 1'b1;
                     end
                  end
               end
               default: state_q <= WAIT_THR;
            endcase
         end
      end
   end

   assign pulse_start = pulse_start_q;
   assign pulse_end   = pulse_end_q;
   assign in_pulse    = in_pulse_q;
   assign pulse_toa   = pulse_toa_q;
   assign pulse_width = pulse_width_q;

`ifdef PEAK_POWER_EN
   logic [POWER_W-1:0] peak_run_q;
   logic [POWER_W-1:0] pulse_peak_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         peak_run_q   <= '0;
         pulse_peak_q <= '0;
      end else if (!threshold_calculated) begin
         peak_run_q <= '0;
      end else begin
         if (pwr_valid) begin
            if (state_q == IDLE) begin
               if (above_valid) peak_run_q <= pwr;
            end else if ((state_q != WAIT_THR) && (pwr > peak_run_q)) begin
               peak_run_q <= pwr;
            end
         end
         if (end_fire) pulse_peak_q <= (pwr > peak_run_q) ? pwr : peak_run_q;
      end
   end

   assign pulse_peak = pulse_peak_q;
`else
   // Peak tracking is not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_detector.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_pulse_detector : directed self-checking bench for the detector|
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_pulse_detector;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] real_part;
   logic [15:0] imag_part;
   logic        data_valid;
   logic [47:0] threshold;
   logic        threshold_calculated;
   logic        pulse_start;
   logic        pulse_end;
   logic [31:0] pulse_toa;
   logic [23:0] pulse_width;
   logic        in_pulse;
`ifdef PEAK_POWER_EN
   logic [31:0] pulse_peak;
`endif

   pulse_detector dut (
      .clk                  (clk),
      .reset                (reset),
      .real_part            (real_part),
      .imag_part            (imag_part),
      .data_valid           (data_valid),
      .threshold            (threshold),
      .threshold_calculated (threshold_calculated),
      .pulse_start          (pulse_start),
      .pulse_end            (pulse_end),
      .pulse_toa            (pulse_toa),
      .pulse_width          (pulse_width),
      .in_pulse             (in_pulse)
`ifdef PEAK_POWER_EN
      ,
      .pulse_peak           (pulse_peak)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor: latches what each strobe carried and when it appeared.
   int          n_start = 0;
   int          n_end   = 0;
   int          start_cyc;
   int          end_cyc;
   logic [31:0] toa_cap;
   logic [23:0] width_cap;
   logic        inp_at_start;
   logic        inp_at_end;
`ifdef PEAK_POWER_EN
   logic [31:0] peak_cap;
`endif

   always @(negedge clk) begin
      if (pulse_start) begin
         n_start      <= n_start + 1;
         start_cyc    <= cyc;
         toa_cap      <= pulse_toa;
         inp_at_start <= in_pulse;
      end
      if (pulse_end) begin
         n_end      <= n_end + 1;
         end_cyc    <= cyc;
         width_cap  <= pulse_width;
         inp_at_end <= in_pulse;
`ifdef PEAK_POWER_EN
         peak_cap   <= pulse_peak;
`endif
      end
   end

   int n_cmp  = 0;
   int n_fail = 0;
   int tb_ts  = 0;
   int drv_cyc;
   int drv_ts;

   task automatic apply(input logic [15:0] re, input logic [15:0] im, input logic v);
      @(negedge clk);
      real_part  = re;
      imag_part  = im;
      data_valid = v;
      drv_cyc    = cyc;
      drv_ts     = tb_ts;
      if (v) tb_ts = tb_ts + 1;
   endtask

   task automatic hi();  apply(16'h7FFF, 16'h7FFF, 1'b1); endtask
   task automatic lo();  apply(16'h4000, 16'h4000, 1'b1); endtask
   task automatic eq();  apply(16'h8000, 16'h0000, 1'b1); endtask
   task automatic gap(); apply(16'h0000, 16'h0000, 1'b0); endtask
   task automatic flush(input int n); repeat (n) gap(); endtask

   task automatic do_reset();
      @(negedge clk);
      reset      = 1'b1;
      data_valid = 1'b0;
      tb_ts      = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; data_valid = 1'b0; threshold_calculated = 1'b0;
      threshold = 48'h0000_4000_0000; real_part = '0; imag_part = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (pulse_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", pulse_start); end
      n_cmp++; if (pulse_end !== 1'b0) begin n_fail++; $display("FAIL reset_end: got %b expected 0", pulse_end); end
      n_cmp++; if (in_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_in_pulse: got %b expected 0", in_pulse); end
      n_cmp++; if (pulse_toa !== 32'd0) begin n_fail++; $display("FAIL reset_toa: got %h expected 0", pulse_toa); end
      n_cmp++; if (pulse_width !== 24'd0) begin n_fail++; $display("FAIL reset_width: got %h expected 0", pulse_width); end
`ifdef PEAK_POWER_EN
      n_cmp++; if (pulse_peak !== 32'd0) begin n_fail++; $display("FAIL reset_peak: got %h expected 0", pulse_peak); end
`endif
      reset = 1'b0;
   endtask

   task automatic test_wait_thr();
      int s0, e0;
      s0 = n_start; e0 = n_end;
      repeat (10) hi();
      flush(6);
      n_cmp++; if (n_start - s0 !== 0) begin n_fail++; $display("FAIL wait_thr_start: got %0d expected 0", n_start - s0); end
      n_cmp++; if (n_end - e0 !== 0) begin n_fail++; $display("FAIL wait_thr_end: got %0d expected 0", n_end - e0); end
      n_cmp++; if (in_pulse !== 1'b0) begin n_fail++; $display("FAIL wait_thr_in_pulse: got %b expected 0", in_pulse); end
      threshold_calculated = 1'b1;
      flush(2);
   endtask

   task automatic test_basic();
      int s0, e0, c3, cl;
      do_reset();
      flush(2);
      s0 = n_start; e0 = n_end;
      repeat (5) lo();
      hi(); hi(); hi(); c3 = drv_cyc;
      repeat (5) hi();
      lo(); lo(); lo(); cl = drv_cyc;
      lo(); lo();
      flush(6);
      n_cmp++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL basic_starts: got %0d expected 1", n_start - s0); end
      n_cmp++; if (toa_cap !== 32'd5) begin n_fail++; $display("FAIL basic_toa: got %0d expected 5", toa_cap); end
      n_cmp++; if (start_cyc !== c3 + 3) begin n_fail++; $display("FAIL basic_start_latency: got %0d expected %0d", start_cyc - c3, 3); end
      n_cmp++; if (inp_at_start !== 1'b1) begin n_fail++; $display("FAIL basic_in_pulse_start: got %b expected 1", inp_at_start); end
      n_cmp++; if (n_end - e0 !== 1) begin n_fail++; $display("FAIL basic_ends: got %0d expected 1", n_end - e0); end
      n_cmp++; if (width_cap !== 24'd8) begin n_fail++; $display("FAIL basic_width: got %0d expected 8", width_cap); end
      n_cmp++; if (end_cyc !== cl + 3) begin n_fail++; $display("FAIL basic_end_latency: got %0d expected %0d", end_cyc - cl, 3); end
      n_cmp++; if (inp_at_end !== 1'b1) begin n_fail++; $display("FAIL basic_in_pulse_end: got %b expected 1", inp_at_end); end
      n_cmp++; if (in_pulse !== 1'b0) begin n_fail++; $display("FAIL basic_in_pulse_after: got %b expected 0", in_pulse); end
   endtask

   task automatic test_glitch();
      int s0;
      s0 = n_start;
      hi(); hi(); lo(); hi(); hi(); lo(); lo(); lo();
      flush(6);
      n_cmp++; if (n_start - s0 !== 0) begin n_fail++; $display("FAIL glitch_starts: got %0d expected 0", n_start - s0); end
      n_cmp++; if (in_pulse !== 1'b0) begin n_fail++; $display("FAIL glitch_in_pulse: got %b expected 0", in_pulse); end
   endtask

   task automatic test_gap();
      int s0, e0, t0;
      s0 = n_start; e0 = n_end;
      hi(); t0 = drv_ts;
      repeat (3) hi();
      lo(); lo();
      repeat (4) hi();
      lo(); lo(); lo();
      flush(6);
      n_cmp++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL gap_starts: got %0d expected 1", n_start - s0); end
      n_cmp++; if (n_end - e0 !== 1) begin n_fail++; $display("FAIL gap_ends: got %0d expected 1", n_end - e0); end
      n_cmp++; if (width_cap !== 24'd10) begin n_fail++; $display("FAIL gap_width: got %0d expected 10", width_cap); end
      n_cmp++; if (toa_cap !== 32'(t0)) begin n_fail++; $display("FAIL gap_toa: got %0d expected %0d", toa_cap, t0); end
   endtask

   task automatic test_boundary();
      int s0, e0;
      s0 = n_start; e0 = n_end;
      eq(); eq(); eq();
      flush(6);
      n_cmp++; if (n_start - s0 !== 0) begin n_fail++; $display("FAIL equal_is_below: got %0d starts expected 0", n_start - s0); end
      hi(); gap(); hi(); gap(); gap(); hi(); eq(); hi(); gap(); lo(); lo(); lo();
      flush(6);
      n_cmp++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL valid_gap_starts: got %0d expected 1", n_start - s0); end
      n_cmp++; if (n_end - e0 !== 1) begin n_fail++; $display("FAIL valid_gap_ends: got %0d expected 1", n_end - e0); end
      n_cmp++; if (width_cap !== 24'd5) begin n_fail++; $display("FAIL valid_gap_width: got %0d expected 5", width_cap); end
   endtask

`ifdef PEAK_POWER_EN
   task automatic test_peak();
      int e0;
      e0 = n_end;
      lo(); lo(); hi(); hi(); apply(16'h8000, 16'h8000, 1'b1); hi(); hi();
      lo(); lo(); lo();
      flush(6);
      n_cmp++; if (n_end - e0 !== 1) begin n_fail++; $display("FAIL peak_ends: got %0d expected 1", n_end - e0); end
      n_cmp++; if (peak_cap !== 32'h8000_0000) begin n_fail++; $display("FAIL peak_value: got %h expected 80000000", peak_cap); end
      n_cmp++; if (width_cap !== 24'd5) begin n_fail++; $display("FAIL peak_width: got %0d expected 5", width_cap); end
   endtask
`endif

   task automatic test_thr_drop();
      int e0;
      e0 = n_end;
      repeat (4) hi();
      flush(4);
      n_cmp++; if (in_pulse !== 1'b1) begin n_fail++; $display("FAIL drop_in_pulse_before: got %b expected 1", in_pulse); end
      @(negedge clk);
      threshold_calculated = 1'b0;
      @(negedge clk);
      n_cmp++; if (in_pulse !== 1'b0) begin n_fail++; $display("FAIL drop_in_pulse_after: got %b expected 0", in_pulse); end
      repeat (4) lo();
      flush(6);
      n_cmp++; if (n_end - e0 !== 0) begin n_fail++; $display("FAIL drop_no_end: got %0d ends expected 0", n_end - e0); end
      threshold_calculated = 1'b1;
      flush(2);
   endtask

   task automatic test_reset_mid_pulse();
      int e0;
      e0 = n_end;
      repeat (4) hi();
      flush(4);
      n_cmp++; if (in_pulse !== 1'b1) begin n_fail++; $display("FAIL rst_in_pulse_before: got %b expected 1", in_pulse); end
      @(negedge clk);
      reset = 1'b1; data_valid = 1'b0; tb_ts = 0;
      @(negedge clk);
      n_cmp++; if (in_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_in_pulse_after: got %b expected 0", in_pulse); end
      @(negedge clk);
      reset = 1'b0;
      flush(2);
      repeat (3) lo();
      flush(6);
      n_cmp++; if (n_end - e0 !== 0) begin n_fail++; $display("FAIL rst_no_end: got %0d ends expected 0", n_end - e0); end
   endtask

   task automatic test_after_reset();
      int s0;
      s0 = n_start;
      hi(); hi(); hi(); lo(); lo(); lo();
      flush(6);
      n_cmp++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL post_rst_starts: got %0d expected 1", n_start - s0); end
      n_cmp++; if (toa_cap !== 32'd3) begin n_fail++; $display("FAIL post_rst_toa: got %0d expected 3", toa_cap); end
      n_cmp++; if (width_cap !== 24'd3) begin n_fail++; $display("FAIL post_rst_width: got %0d expected 3", width_cap); end
   endtask

   initial begin
      test_reset();
      test_wait_thr();
      test_basic();
      test_glitch();
      test_gap();
      test_boundary();
`ifdef PEAK_POWER_EN
      test_peak();
`endif
      test_thr_drop();
      test_reset_mid_pulse();
      test_after_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
